fp_alu_issue_queue: RTL and testbench
=====================================

// Module: fp_alu_issue_queue
// PURPOSE
//  Upstream front end for the floating-point ALU (flopALU). Buffers {op,in1,in2}
//  requests from a valid/ready producer in a FIFO and issues one at a time on
//  registered ALU operand ports. Waits ALU_LAT cycles, then captures the ALU
//  result into a valid/ready result register with backpressure.
//  Replaces free-running per-clock operand driving with ordered, flow-controlled issue.
// PARAMETERS
//  N       32  operand/result width (IEEE-754 single)
//  DEPTH   4   request FIFO entries; power of two, >=2
//  ALU_LAT 0   extra ALU pipeline cycles between issue and capture (0 = combinational ALU)
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid&&in_ready
//  in_a       in   N      operand A
//  in_b       in   N      operand B
//  in_op      in   2      ALU op code, passed through unmodified
//  alu_in1    out  N      registered operand to ALU in1
//  alu_in2    out  N      registered operand to ALU in2
//  alu_op     out  2      registered op to ALU op
//  alu_out    in   N      ALU result
//  res_valid  out  1      result valid
//  res_ready  in   1      result consumed when res_valid&&res_ready
//  res_data   out  N      captured result
//  res_op     out  2      op code the result belongs to
//  level      out  $clog2(DEPTH)+1  FIFO occupancy (excludes the in-flight request)
//  busy       out  1      FSM != IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; FIFO emptied, FSM=IDLE. Reset mid-operation
//   discards queued, in-flight and held results; no res_valid pulse follows.
//  FIFO: in_ready = (level!=DEPTH). Push and pop in the same cycle leave level unchanged.
//   A push while full is impossible (in_ready=0); a push in the cycle FIFO pops from full is
//   still refused. Pointers wrap modulo DEPTH. Order strictly FIFO.
//  FSM states IDLE, WAIT, HOLD:
//   IDLE: if level!=0, pop head into alu_in1/alu_in2/alu_op, load cnt=ALU_LAT, -> WAIT.
//   WAIT: if cnt==0, res_data<=alu_out, res_op<=alu_op, res_valid<=1, -> HOLD;
//         else cnt<=cnt-1.
//   HOLD: when res_ready: res_valid<=0; if level!=0 pop+issue same edge, -> WAIT;
//         else -> IDLE. While !res_ready, hold all result and ALU ports stable.
//  alu_* ports change only at issue edges; otherwise hold last value.
//  Latency: push at edge P into empty idle block -> issue edge P+1 -> res_valid at
//   edge P+2+ALU_LAT. Back-to-back throughput with res_ready=1: one result per 2+ALU_LAT cycles.
//  Request arriving in IDLE is issued only after it is written (no FIFO bypass).
// CONFIGURATION
//  FP_CLASS_FLAGS_EN defined: adds output res_flags[3:0] = {nan,inf,zero,neg}, decoded
//   from alu_out at capture time and registered with res_data. Reset value 0.
//   nan: exp=all-ones & mant!=0. inf: exp=all-ones & mant==0. zero: exp==0 & mant==0.
//   neg: sign bit.
//  Undefined: port absent, no decode logic; all other behaviour identical.
// TESTING (golden ALU model; op 00=add)
//  Push {00,0x3F800000,0x40000000}, res_ready=1 -> res_valid at P+2, res_data=0x40400000, res_op=00.
//  DEPTH=4, res_ready=0, push 6 -> 5 accepted, in_ready=0 after 5th, level=4, busy=1.
//  Then res_ready=1 -> 5 results in push order, one per 2 cycles, level 4->0, in_ready=1 again.
//  ALU_LAT=3: single request -> res_valid at P+5; alu_in1/alu_in2 stable throughout WAIT.
//  rst=1 in WAIT with 3 queued -> next edge level=0, res_valid=0, busy=0, alu_* =0, in_ready=1.
//  FP_CLASS_FLAGS_EN: result 0x7FC00000 -> flags 4'b1000; 0xFF800000 -> 4'b0101; 0x00000000 -> 4'b0010.

Source files
------------

// File: rtl/fp_alu_issue_queue.sv
// Request FIFO plus single-issue sequencer in front of the floating-point ALU; results are held in a valid/ready register.
// Optional macro FP_CLASS_FLAGS_EN adds res_flags = {nan,inf,zero,neg} captured with each result.
module fp_alu_issue_queue #(
   parameter int N       = 32,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N-1:0]               in_a,
   input  logic [N-1:0]               in_b,
   input  logic [1:0]                 in_op,
   output logic [N-1:0]               alu_in1,
   output logic [N-1:0]               alu_in2,
   output logic [1:0]                 alu_op,
   input  logic [N-1:0]               alu_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [N-1:0]               res_data,
   output logic [1:0]                 res_op,
   output logic [$clog2(DEPTH):0]     level,
`ifdef FP_CLASS_FLAGS_EN
   output logic [3:0]                 res_flags,
`endif
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
   localparam int EW = 8;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   logic [2*N+1:0] r_mem [DEPTH];
   logic [AW-1:0]  r_wp;
   logic [AW-1:0]  r_rp;
   logic [LW-1:0]  r_level;
   logic [CW-1:0]  r_cnt;
   state_t         r_state;

   logic           w_push;
   logic           w_pop;
   logic [2*N+1:0] w_head;

`ifdef FP_CLASS_FLAGS_EN
   logic [3:0]     r_flags;

   function automatic logic [3:0] fp_class(input logic [N-1:0] v);
      logic [EW-1:0]  e;
      logic [N-EW-2:0] m;
      e = v[N-2:N-1-EW];
      m = v[N-EW-2:0];
      fp_class = {(&e) && (m != '0), (&e) && (m == '0), (e == '0) && (m == '0), v[N-1]};
   endfunction

   assign res_flags = r_flags;
`endif

   assign in_ready = (r_level != LW'(DEPTH));
   assign level    = r_level;
   assign busy     = (r_state != IDLE);
   assign w_push   = in_valid && in_ready;
   // A pop is also an issue: it happens from IDLE, or from HOLD on the edge the result is taken.
   assign w_pop    = (r_level != '0) &&
                     ((r_state == IDLE) || ((r_state == HOLD) && res_ready));
   assign w_head   = r_mem[r_rp];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {in_op, in_a, in_b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_level   <= '0;
         r_cnt     <= '0;
         r_state   <= IDLE;
         alu_in1   <= '0;
         alu_in2   <= '0;
         alu_op    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
`ifdef FP_CLASS_FLAGS_EN
         r_flags   <= '0;
`endif
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase

         if (w_pop) begin
            alu_op  <= w_head[2*N+1:2*N];
            alu_in1 <= w_head[2*N-1:N];
            alu_in2 <= w_head[N-1:0];
            r_cnt   <= CW'(ALU_LAT);
         end

         case (r_state)
            IDLE: if (w_pop) r_state <= WAIT;
            WAIT: begin
               if (r_cnt == '0) begin
                  res_data  <= alu_out;
                  res_op    <= alu_op;
                  res_valid <= 1'b1;
`ifdef FP_CLASS_FLAGS_EN
                  r_flags   <= fp_class(alu_out);
`endif
                  r_state   <= HOLD;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  r_state   <= w_pop ? WAIT : IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_alu_issue_queue.sv
// Directed bench for fp_alu_issue_queue: one instance with a combinational ALU, one with ALU_LAT=3.
// The ALU stand-in is a lookup of hand-computed IEEE-754 results.
module tb_fp_alu_issue_queue;

   localparam int N = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance u0: ALU_LAT=0
   logic          in_valid0, in_ready0, res_valid0, res_ready0, busy0;
   logic [N-1:0]  in_a0, in_b0, alu_in1_0, alu_in2_0, alu_out0, res_data0;
   logic [1:0]    in_op0, alu_op0, res_op0;
   logic [2:0]    level0;
   // Instance u3: ALU_LAT=3
   logic          in_valid3, in_ready3, res_valid3, res_ready3, busy3;
   logic [N-1:0]  in_a3, in_b3, alu_in1_3, alu_in2_3, alu_out3, res_data3;
   logic [1:0]    in_op3, alu_op3, res_op3;
   logic [2:0]    level3;
`ifdef FP_CLASS_FLAGS_EN
   logic [3:0]    res_flags0, res_flags3;
`endif

   int checks = 0;
   int passed = 0;

   function automatic logic [N-1:0] alu_model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] r;
      r = 32'hDEADBEEF;
      if      (op == 2'b00 && a == 32'h3F800000 && b == 32'h3F800000) r = 32'h40000000; // 1+1
      else if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000; // 1+2
      else if (op == 2'b00 && a == 32'h40000000 && b == 32'h40000000) r = 32'h40800000; // 2+2
      else if (op == 2'b00 && a == 32'h40800000 && b == 32'h40800000) r = 32'h41000000; // 4+4
      else if (op == 2'b01 && a == 32'h40000000 && b == 32'h3F800000) r = 32'h3F800000; // 2-1
      else if (op == 2'b01 && a == 32'h3F800000 && b == 32'h3F800000) r = 32'h00000000; // 1-1
      else if (op == 2'b10 && a == 32'h40000000 && b == 32'h40000000) r = 32'h40800000; // 2*2
      else if (op == 2'b00 && a == 32'h7F800000 && b == 32'hFF800000) r = 32'h7FC00000; // inf+-inf
      else if (op == 2'b00 && a == 32'hFF800000 && b == 32'hFF800000) r = 32'hFF800000; // -inf+-inf
      return r;
   endfunction

   assign alu_out0 = alu_model(alu_op0, alu_in1_0, alu_in2_0);
   assign alu_out3 = alu_model(alu_op3, alu_in1_3, alu_in2_3);

   fp_alu_issue_queue #(.N(N), .DEPTH(4), .ALU_LAT(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .in_a(in_a0), .in_b(in_b0), .in_op(in_op0),
      .alu_in1(alu_in1_0), .alu_in2(alu_in2_0), .alu_op(alu_op0), .alu_out(alu_out0),
      .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0), .res_op(res_op0),
      .level(level0),
`ifdef FP_CLASS_FLAGS_EN
      .res_flags(res_flags0),
`endif
      .busy(busy0));

   fp_alu_issue_queue #(.N(N), .DEPTH(4), .ALU_LAT(3)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_a(in_a3), .in_b(in_b3), .in_op(in_op3),
      .alu_in1(alu_in1_3), .alu_in2(alu_in2_3), .alu_op(alu_op3), .alu_out(alu_out3),
      .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3), .res_op(res_op3),
      .level(level3),
`ifdef FP_CLASS_FLAGS_EN
      .res_flags(res_flags3),
`endif
      .busy(busy3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One request through u0 with res_ready=1; bounded wait for the result.
   task automatic run_one(input string tag, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp, input logic [3:0] expf);
      bit seen;
      seen = 1'b0;
      res_ready0 = 1'b1;
      in_valid0 = 1'b1; in_op0 = op; in_a0 = a; in_b0 = b;
      tick();
      in_valid0 = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         if (res_valid0) begin
            seen = 1'b1;
            chk({tag, "_data"}, res_data0, exp);
            chk({tag, "_op"}, {30'd0, res_op0}, {30'd0, op});
`ifdef FP_CLASS_FLAGS_EN
            chk({tag, "_flags"}, {28'd0, res_flags0}, {28'd0, expf});
`endif
         end
      end
      chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
      tick();
   endtask

   logic [1:0]   v_op [6];
   logic [N-1:0] v_a  [6];
   logic [N-1:0] v_b  [6];
   logic [N-1:0] v_r  [6];

   initial begin
      int nacc;
      int nres;
      int last_c;
      logic [3:0] unused_f;
      unused_f = 4'd0;
      v_op[0] = 2'b00; v_a[0] = 32'h3F800000; v_b[0] = 32'h3F800000; v_r[0] = 32'h40000000;
      v_op[1] = 2'b00; v_a[1] = 32'h3F800000; v_b[1] = 32'h40000000; v_r[1] = 32'h40400000;
      v_op[2] = 2'b00; v_a[2] = 32'h40000000; v_b[2] = 32'h40000000; v_r[2] = 32'h40800000;
      v_op[3] = 2'b01; v_a[3] = 32'h40000000; v_b[3] = 32'h3F800000; v_r[3] = 32'h3F800000;
      v_op[4] = 2'b10; v_a[4] = 32'h40000000; v_b[4] = 32'h40000000; v_r[4] = 32'h40800000;
      v_op[5] = 2'b00; v_a[5] = 32'h40800000; v_b[5] = 32'h40800000; v_r[5] = 32'h41000000;

      rst = 1'b1;
      in_valid0 = 0; in_a0 = 0; in_b0 = 0; in_op0 = 0; res_ready0 = 0;
      in_valid3 = 0; in_a3 = 0; in_b3 = 0; in_op3 = 0; res_ready3 = 0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid0}, 32'd0);
      chk("rst_level", {29'd0, level0}, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_alu_in1", alu_in1_0, 32'd0);
      chk("rst_res_data", res_data0, 32'd0);

      // Single request, combinational ALU: issue at P+1, result at P+2
      res_ready0 = 1'b1;
      in_valid0 = 1'b1; in_op0 = 2'b00; in_a0 = 32'h3F800000; in_b0 = 32'h40000000;
      tick();
      in_valid0 = 1'b0;
      chk("p0_level", {29'd0, level0}, 32'd1);
      chk("p0_busy", {31'd0, busy0}, 32'd0);
      chk("p0_no_bypass", alu_in1_0, 32'd0);
      tick();
      chk("p1_busy", {31'd0, busy0}, 32'd1);
      chk("p1_level", {29'd0, level0}, 32'd0);
      chk("p1_alu_in1", alu_in1_0, 32'h3F800000);
      chk("p1_alu_in2", alu_in2_0, 32'h40000000);
      chk("p1_res_valid", {31'd0, res_valid0}, 32'd0);
      tick();
      chk("p2_res_valid", {31'd0, res_valid0}, 32'd1);
      chk("p2_res_data", res_data0, 32'h40400000);
      chk("p2_res_op", {30'd0, res_op0}, 32'd0);
      tick();
      chk("p3_res_valid", {31'd0, res_valid0}, 32'd0);
      chk("p3_busy", {31'd0, busy0}, 32'd0);

      // Backpressure: 6 offered, 5 accepted
      res_ready0 = 1'b0;
      nacc = 0;
      for (int k = 0; k < 6; k++) begin
         bit acc;
         in_valid0 = 1'b1;
         in_op0 = v_op[nacc]; in_a0 = v_a[nacc]; in_b0 = v_b[nacc];
         acc = in_ready0;
         tick();
         if (acc) nacc++;
      end
      chk("bp_accepted", nacc, 32'd5);
      chk("bp_level", {29'd0, level0}, 32'd4);
      chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
      chk("bp_busy", {31'd0, busy0}, 32'd1);
      chk("bp_held_data", res_data0, v_r[0]);
      chk("bp_held_alu_in1", alu_in1_0, v_a[0]);

      // Drain in order; the 6th request stays offered on the pop-from-full edge
      res_ready0 = 1'b1;
      nres = 0;
      last_c = 0;
      for (int c = 0; c < 40 && nres < 5; c++) begin
         if (res_valid0) begin
            chk("drain_data", res_data0, v_r[nres]);
            chk("drain_op", {30'd0, res_op0}, {30'd0, v_op[nres]});
            if (nres > 0) chk("drain_spacing", c - last_c, 32'd2);
            last_c = c;
            nres++;
         end
         tick();
         if (c == 0) begin
            chk("full_pop_push_refused", {29'd0, level0}, 32'd3);
            in_valid0 = 1'b0;
         end
      end
      chk("drain_count", nres, 32'd5);
      chk("drain_level", {29'd0, level0}, 32'd0);
      chk("drain_in_ready", {31'd0, in_ready0}, 32'd1);
      chk("drain_busy", {31'd0, busy0}, 32'd0);

      // More ops on u0, including classification vectors
      run_one("mul", 2'b10, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
      run_one("nan", 2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000);
      run_one("ninf", 2'b00, 32'hFF800000, 32'hFF800000, 32'hFF800000, 4'b0101);
      run_one("zero", 2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0010);

      // ALU_LAT=3: result at P+5, operands stable through WAIT
      res_ready3 = 1'b1;
      in_valid3 = 1'b1; in_op3 = 2'b00; in_a3 = 32'h3F800000; in_b3 = 32'h40000000;
      tick();
      in_valid3 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("lat_no_valid", {31'd0, res_valid3}, 32'd0);
         chk("lat_in1_stable", alu_in1_3, 32'h3F800000);
         chk("lat_in2_stable", alu_in2_3, 32'h40000000);
      end
      tick();
      chk("lat_res_valid", {31'd0, res_valid3}, 32'd1);
      chk("lat_res_data", res_data3, 32'h40400000);
      tick();
      chk("lat_idle", {31'd0, busy3}, 32'd0);

      // Reset in WAIT with 3 queued
      res_ready3 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid3 = 1'b1; in_op3 = v_op[k]; in_a3 = v_a[k]; in_b3 = v_b[k];
         tick();
      end
      in_valid3 = 1'b0;
      chk("pre_rst_level", {29'd0, level3}, 32'd3);
      chk("pre_rst_busy", {31'd0, busy3}, 32'd1);
      chk("pre_rst_wait", {31'd0, res_valid3}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_level", {29'd0, level3}, 32'd0);
      chk("mid_rst_res_valid", {31'd0, res_valid3}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy3}, 32'd0);
      chk("mid_rst_alu_in1", alu_in1_3, 32'd0);
      chk("mid_rst_alu_op", {30'd0, alu_op3}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready3}, 32'd1);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("post_rst_no_valid", {31'd0, res_valid3}, 32'd0);
      end
      chk("post_rst_level", {29'd0, level3}, 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
